video_timing_gen: RTL and testbench

//  Parametrised raster timing generator; successor of the fixed 310x263 sync generator.

---
 rtl/video_timing_pkg.sv | 23 ++
 rtl/vtg_counter.sv | 33 +++
 rtl/video_timing_gen.sv | 157 +++++++++++++++
 tb/tb_video_timing_gen.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/video_timing_pkg.sv
// Default raster timing constants, signed pixel-coordinate type and sync polarity helper
// shared by the video timing generator and its sub-modules.
package video_timing_pkg;

  localparam int VTG_H_TOTAL    = 310;
  localparam int VTG_V_TOTAL    = 263;
  localparam int VTG_H_ACTIVE   = 256;
  localparam int VTG_V_ACTIVE   = 192;
  localparam int VTG_H_BORDER   = 10;
  localparam int VTG_V_BORDER   = 26;
  localparam int VTG_H_SYNC_LEN = 23;
  localparam int VTG_V_SYNC_LEN = 3;
  localparam int VTG_SHIFT_W    = 4;
  localparam int VTG_POS_W      = 9;
  localparam bit VTG_SYNC_POL   = 1'b1;

  typedef logic signed [VTG_POS_W-1:0] pos_t;

  function automatic logic sync_level(input logic active, input logic pol);
    return active ? pol : ~pol;
  endfunction

endpackage

// File: rtl/vtg_counter.sv
// Modulo-N counter with a combinational wrap flag (high in the enabled cycle at N-1).
module vtg_counter #(
  parameter int N = 310,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en_i,
  output logic [W-1:0] count_o,
  output logic         wrap_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    wrap_o  = en_i && (count_q == W'(N - 1));
    count_d = count_q;
    if (en_i) begin
      count_d = wrap_o ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: registered syncs, scroll-adjusted signed pixel coordinates and strobes.
// Define VTG_RASTER_IRQ_EN to add the raster interrupt (irqLine/irqAck/irq).
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int H_TOTAL    = VTG_H_TOTAL,
  parameter int V_TOTAL    = VTG_V_TOTAL,
  parameter int H_ACTIVE   = VTG_H_ACTIVE,
  parameter int V_ACTIVE   = VTG_V_ACTIVE,
  parameter int H_BORDER   = VTG_H_BORDER,
  parameter int V_BORDER   = VTG_V_BORDER,
  parameter int H_SYNC_LEN = VTG_H_SYNC_LEN,
  parameter int V_SYNC_LEN = VTG_V_SYNC_LEN,
  parameter int SHIFT_W    = VTG_SHIFT_W,
  parameter int POS_W      = VTG_POS_W,
  parameter bit SYNC_POL   = VTG_SYNC_POL
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [SHIFT_W-1:0]      hShift,
  input  logic [SHIFT_W-1:0]      vShift,
  output logic                    hSync,
  output logic                    vSync,
  output logic signed [POS_W-1:0] xPos,
  output logic signed [POS_W-1:0] yPos,
  output logic                    isActive,
  output logic                    lineStart,
  output logic                    frameStart
`ifdef VTG_RASTER_IRQ_EN
  ,
  input  logic [POS_W-1:0]        irqLine,
  input  logic                    irqAck,
  output logic                    irq
`endif
);

  localparam int HCW = $clog2(H_TOTAL);
  localparam int VCW = $clog2(V_TOTAL);

  // The worst-case scroll must still leave the visible window clear of the sync pulse.
  if (H_BORDER + (2 ** SHIFT_W) - 1 + H_ACTIVE > H_TOTAL - H_SYNC_LEN) begin : g_h_chk
    $error("video_timing_gen: horizontal window plus maximum scroll overlaps hSync");
  end
  if (V_BORDER + (2 ** SHIFT_W) - 1 + V_ACTIVE > V_TOTAL - V_SYNC_LEN) begin : g_v_chk
    $error("video_timing_gen: vertical window plus maximum scroll overlaps vSync");
  end

  logic [HCW-1:0]     col;
  logic [VCW-1:0]     line;
  logic               col_wrap;
  logic               frame_end;

  logic [SHIFT_W-1:0] hshl_q, hshl_d;
  logic [SHIFT_W-1:0] vshl_q, vshl_d;

  logic signed [POS_W-1:0] x_d, y_d;
  logic               active_d, hs_act, vs_act, ls_d, fs_d;

  logic               hsync_q, vsync_q, active_q, ls_q, fs_q;
  logic signed [POS_W-1:0] x_q, y_q;

  vtg_counter #(.N(H_TOTAL), .W(HCW)) u_col_cnt (
    .clk     (clk),
    .reset   (reset),
    .en_i    (1'b1),
    .count_o (col),
    .wrap_o  (col_wrap)
  );

  vtg_counter #(.N(V_TOTAL), .W(VCW)) u_line_cnt (
    .clk     (clk),
    .reset   (reset),
    .en_i    (col_wrap),
    .count_o (line),
    .wrap_o  (frame_end)
  );

  always_comb begin
    hshl_d = hshl_q;
    vshl_d = vshl_q;
    // Scroll is only picked up on the very last cycle of a frame so a frame never tears.
    if (frame_end) begin
      hshl_d = hShift;
      vshl_d = vShift;
    end

    x_d = POS_W'(col) - POS_W'(H_BORDER) - POS_W'(hshl_q);
    y_d = POS_W'(line) - POS_W'(V_BORDER) - POS_W'(vshl_q);

    active_d = !x_d[POS_W-1] && ({1'b0, x_d} < (POS_W + 1)'(H_ACTIVE)) &&
               !y_d[POS_W-1] && ({1'b0, y_d} < (POS_W + 1)'(V_ACTIVE));

    hs_act = col >= HCW'(H_TOTAL - H_SYNC_LEN);
    vs_act = line < VCW'(V_SYNC_LEN);
    ls_d   = (col == '0);
    fs_d   = (col == '0) && (line == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hshl_q   <= '0;
      vshl_q   <= '0;
      hsync_q  <= ~SYNC_POL;
      vsync_q  <= ~SYNC_POL;
      x_q      <= '0;
      y_q      <= '0;
      active_q <= 1'b0;
      ls_q     <= 1'b0;
      fs_q     <= 1'b0;
    end else begin
      hshl_q   <= hshl_d;
      vshl_q   <= vshl_d;
      hsync_q  <= sync_level(hs_act, SYNC_POL);
      vsync_q  <= sync_level(vs_act, SYNC_POL);
      x_q      <= x_d;
      y_q      <= y_d;
      active_q <= active_d;
      ls_q     <= ls_d;
      fs_q     <= fs_d;
    end
  end

  assign hSync      = hsync_q;
  assign vSync      = vsync_q;
  assign xPos       = x_q;
  assign yPos       = y_q;
  assign isActive   = active_q;
  assign lineStart  = ls_q;
  assign frameStart = fs_q;

`ifdef VTG_RASTER_IRQ_EN
  logic irq_q, irq_d, irq_set;

  always_comb begin
    irq_set = (col == '0) && (32'(line) == 32'(irqLine));
    irq_d   = irq_q;
    if (irqAck) begin
      irq_d = 1'b0;
    end
    // A new match beats a coincident acknowledge so no raster event is lost.
    if (irq_set) begin
      irq_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign irq = irq_q;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: directed default-timing vectors plus a small-raster instance
// driven with random scroll and compared each cycle against an arithmetic reference model.
module tb_video_timing_gen;

  localparam int S_HT  = 40;
  localparam int S_VT  = 30;
  localparam int S_HA  = 12;
  localparam int S_VA  = 8;
  localparam int S_HB  = 3;
  localparam int S_VB  = 2;
  localparam int S_HS  = 5;
  localparam int S_VS  = 2;
  localparam bit S_POL = 1'b0;
  localparam int S_FR  = S_HT * S_VT;

  logic clk;
  int   n_chk = 0;
  int   n_err = 0;

  logic       r;
  logic [3:0] hs, vs;
  logic       hSync, vSync, isActive, lineStart, frameStart;
  logic signed [8:0] xPos, yPos;

  logic       rst_s;
  logic [3:0] hs_s, vs_s;
  logic       hSync_s, vSync_s, isActive_s, lineStart_s, frameStart_s;
  logic signed [8:0] xPos_s, yPos_s;

`ifdef VTG_RASTER_IRQ_EN
  logic [8:0] irqLine, irqLine_s;
  logic       irqAck, irqAck_s, irq, irq_s;
`endif

  video_timing_gen dut (
    .clk        (clk),
    .reset      (r),
    .hShift     (hs),
    .vShift     (vs),
    .hSync      (hSync),
    .vSync      (vSync),
    .xPos       (xPos),
    .yPos       (yPos),
    .isActive   (isActive),
    .lineStart  (lineStart),
    .frameStart (frameStart)
`ifdef VTG_RASTER_IRQ_EN
    ,
    .irqLine    (irqLine),
    .irqAck     (irqAck),
    .irq        (irq)
`endif
  );

  video_timing_gen #(
    .H_TOTAL(S_HT), .V_TOTAL(S_VT), .H_ACTIVE(S_HA), .V_ACTIVE(S_VA),
    .H_BORDER(S_HB), .V_BORDER(S_VB), .H_SYNC_LEN(S_HS), .V_SYNC_LEN(S_VS),
    .SHIFT_W(4), .POS_W(9), .SYNC_POL(S_POL)
  ) dut_s (
    .clk        (clk),
    .reset      (rst_s),
    .hShift     (hs_s),
    .vShift     (vs_s),
    .hSync      (hSync_s),
    .vSync      (vSync_s),
    .xPos       (xPos_s),
    .yPos       (yPos_s),
    .isActive   (isActive_s),
    .lineStart  (lineStart_s),
    .frameStart (frameStart_s)
`ifdef VTG_RASTER_IRQ_EN
    ,
    .irqLine    (irqLine_s),
    .irqAck     (irqAck_s),
    .irq        (irq_s)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [22:0] pk(input logic h, input logic v, input logic a, input logic l,
                                     input logic f, input logic [8:0] x, input logic [8:0] y);
    return {h, v, a, l, f, x, y};
  endfunction

  function automatic logic [22:0] model_s(input int col, input int line, input int sx, input int sy);
    int x, y;
    logic a, h, v;
    x = col - S_HB - sx;
    y = line - S_VB - sy;
    a = (x >= 0) && (x < S_HA) && (y >= 0) && (y < S_VA);
    h = (col >= S_HT - S_HS) ? S_POL : !S_POL;
    v = (line < S_VS) ? S_POL : !S_POL;
    return pk(h, v, a, col == 0, (col == 0) && (line == 0), 9'(x), 9'(y));
  endfunction

  typedef struct {
    int          k;
    logic [22:0] exp;
  } vec_t;

  vec_t tbl[14];
  int   kd;

  task automatic adv(input int n);
    repeat (n) @(negedge clk);
    kd += n;
  endtask

  function automatic logic [22:0] cur_d();
    return pk(hSync, vSync, isActive, lineStart, frameStart, xPos, yPos);
  endfunction

  // Small raster: random scroll every cycle, reference computed from frame position.
  initial begin
    int ks, p, col, line, sh_h, sh_v, last_fs, act_cnt;
    logic [22:0] exp_v;
    rst_s = 1'b1; hs_s = '0; vs_s = '0;
`ifdef VTG_RASTER_IRQ_EN
    irqLine_s = 9'h1FF; irqAck_s = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("small_reset", 32'(pk(hSync_s, vSync_s, isActive_s, lineStart_s, frameStart_s, xPos_s, yPos_s)),
        32'(pk(!S_POL, !S_POL, 1'b0, 1'b0, 1'b0, 9'h000, 9'h000)));
    rst_s = 1'b0;
    ks = 0; sh_h = 0; sh_v = 0; last_fs = 0; act_cnt = 0;
    forever begin
      @(posedge clk);
      ks++;
      p     = (ks - 1) % S_FR;
      col   = p % S_HT;
      line  = p / S_HT;
      exp_v = model_s(col, line, sh_h, sh_v);
      if (p == S_FR - 1) begin
        sh_h = int'(hs_s);
        sh_v = int'(vs_s);
      end
      @(negedge clk);
      chk($sformatf("small_k%0d", ks),
          32'(pk(hSync_s, vSync_s, isActive_s, lineStart_s, frameStart_s, xPos_s, yPos_s)), 32'(exp_v));
      if (frameStart_s) begin
        if (last_fs > 0) begin
          chk("small_frame_period", 32'(ks - last_fs), 32'(S_FR));
          chk("small_active_count", 32'(act_cnt), 32'(S_HA * S_VA));
        end
        last_fs = ks;
        act_cnt = 0;
      end
      if (isActive_s) act_cnt++;
      hs_s = 4'($urandom);
      vs_s = 4'($urandom);
    end
  end

  initial begin
    int ti, hcnt, lcnt, fcnt;
    tbl[0]  = '{1,     pk(0, 1, 0, 1, 1, 9'h1F6, 9'h1E6)};
    tbl[1]  = '{2,     pk(0, 1, 0, 0, 0, 9'h1F7, 9'h1E6)};
    tbl[2]  = '{11,    pk(0, 1, 0, 0, 0, 9'h000, 9'h1E6)};
    tbl[3]  = '{287,   pk(0, 1, 0, 0, 0, 9'h114, 9'h1E6)};
    tbl[4]  = '{288,   pk(1, 1, 0, 0, 0, 9'h115, 9'h1E6)};
    tbl[5]  = '{310,   pk(1, 1, 0, 0, 0, 9'h12B, 9'h1E6)};
    tbl[6]  = '{311,   pk(0, 1, 0, 1, 0, 9'h1F6, 9'h1E7)};
    tbl[7]  = '{621,   pk(0, 1, 0, 1, 0, 9'h1F6, 9'h1E8)};
    tbl[8]  = '{931,   pk(0, 0, 0, 1, 0, 9'h1F6, 9'h1E9)};
    tbl[9]  = '{8070,  pk(0, 0, 0, 0, 0, 9'h1FF, 9'h000)};
    tbl[10] = '{8071,  pk(0, 0, 1, 0, 0, 9'h000, 9'h000)};
    tbl[11] = '{8326,  pk(0, 0, 1, 0, 0, 9'h0FF, 9'h000)};
    tbl[12] = '{8327,  pk(0, 0, 0, 0, 0, 9'h100, 9'h000)};
    tbl[13] = '{31000, pk(1, 0, 0, 0, 0, 9'h12B, 9'h049)};

    r = 1'b1; hs = 4'd5; vs = 4'd3;
`ifdef VTG_RASTER_IRQ_EN
    irqLine = 9'd100; irqAck = 1'b0;
`endif
    kd = 0;
    repeat (2) @(negedge clk);
    chk("reset_state", 32'(cur_d()), 32'(pk(0, 0, 0, 0, 0, 9'h000, 9'h000)));
    r = 1'b0;

    ti = 0; hcnt = 0; lcnt = 0; fcnt = 0;
    while (kd < 31000) begin
      adv(1);
      if (kd <= 310 && hSync) hcnt++;
      if (kd <= 620 && lineStart) lcnt++;
      if (frameStart) fcnt++;
      if (ti < 14 && tbl[ti].k == kd) begin
        chk($sformatf("vec%0d_k%0d", ti, kd), 32'(cur_d()), 32'(tbl[ti].exp));
        ti++;
      end
    end
    chk("table_rows_hit", 32'(ti), 32'd14);
    chk("hsync_width_line0", 32'(hcnt), 32'd23);
    chk("linestart_count_2lines", 32'(lcnt), 32'd2);
    chk("framestart_count", 32'(fcnt), 32'd1);

`ifdef VTG_RASTER_IRQ_EN
    chk("irq_before_line", 32'(irq), 32'd0);
    irqAck = 1'b1;
    adv(1);
    chk("irq_set_beats_ack", 32'(irq), 32'd1);
    irqAck = 1'b0;
    adv(2);
    chk("irq_hold", 32'(irq), 32'd1);
    irqAck = 1'b1;
    adv(1);
    chk("irq_acked", 32'(irq), 32'd0);
    irqAck = 1'b0;
`endif

    // Abort the frame at line 100 with a single reset cycle.
    adv(31050 - kd);
    r = 1'b1;
    adv(1);
    chk("reset_mid_frame", 32'(cur_d()), 32'(pk(0, 0, 0, 0, 0, 9'h000, 9'h000)));
`ifdef VTG_RASTER_IRQ_EN
    chk("irq_reset", 32'(irq), 32'd0);
`endif
    r = 1'b0;
    kd = 0;
    adv(1);
    chk("after_reset_first", 32'(cur_d()), 32'(tbl[0].exp));
    adv(310 - kd);
    chk("after_reset_k310", 32'(cur_d()), 32'(tbl[5].exp));
    adv(1);
    chk("after_reset_k311", 32'(cur_d()), 32'(tbl[6].exp));

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
